// File: rtl/collision_detector.sv
// Pong collision/score controller: watches ball moves, pulses paddle/wall bounces,
// detects goals, keeps score and sequences serve / play / game-over.
module collision_detector #(
  parameter int unsigned FIELD_H   = 64,
  parameter int unsigned COORD_W   = 6,
  parameter int unsigned PADDLE_H  = 8,
  parameter int unsigned LPAD_X    = 2,
  parameter int unsigned RPAD_X    = 61,
  parameter int unsigned WIN_SCORE = 7,
  parameter int unsigned HOLDOFF   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pos_valid,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] lpad_y,
  input  logic [COORD_W-1:0] rpad_y,
  input  logic               serve_ack,
  output logic               paddle_collision,
  output logic               wall_collision,
  output logic               goal_left,
  output logic               goal_right,
  output logic [3:0]         score_l,
  output logic [3:0]         score_r,
  output logic               serve_req,
  output logic               game_over
);

  localparam int unsigned HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam int unsigned EW = COORD_W + 1;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] phold_q, phold_d, whold_q, whold_d;
  logic          paddle_q, paddle_d, wall_q, wall_d;
  logic          gl_q, gl_d, gr_q, gr_d;
  logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d;

  logic l_ov, r_ov, l_hit, r_hit, w_hit, l_goal, r_goal;

  // Paddle bottom row is computed one bit wider so a low paddle clips instead of wrapping.
  always_comb begin
    l_ov   = (by >= lpad_y) &&
             ({1'b0, by} <= ({1'b0, lpad_y} + EW'(PADDLE_H - 1)));
    r_ov   = (by >= rpad_y) &&
             ({1'b0, by} <= ({1'b0, rpad_y} + EW'(PADDLE_H - 1)));
    l_hit  = (bx <= COORD_W'(LPAD_X)) && l_ov && (phold_q == '0);
    r_hit  = (bx >= COORD_W'(RPAD_X)) && r_ov && (phold_q == '0);
    w_hit  = ((by == '0) || (by == COORD_W'(FIELD_H - 1))) && (whold_q == '0);
    l_goal = (bx == '0) && !l_ov;
    r_goal = (bx == '1) && !r_ov;
  end

  always_comb begin
    state_d   = state_q;
    phold_d   = phold_q;
    whold_d   = whold_q;
    paddle_d  = 1'b0;
    wall_d    = 1'b0;
    gl_d      = 1'b0;
    gr_d      = 1'b0;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    case (state_q)
      IDLE:  state_d = SERVE;
      SERVE: begin
        if (serve_ack) begin
          state_d = PLAY;
          phold_d = '0;
          whold_d = '0;
        end
      end
      PLAY: begin
        if (pos_valid) begin
          if (phold_q != '0) phold_d = phold_q - HW'(1);
          if (whold_q != '0) whold_d = whold_q - HW'(1);
          if (l_goal) begin
            gl_d = 1'b1;
            if (score_r_q < 4'(WIN_SCORE)) score_r_d = score_r_q + 4'd1;
            state_d = (score_r_d == 4'(WIN_SCORE)) ? OVER : SERVE;
          end else if (r_goal) begin
            gr_d = 1'b1;
            if (score_l_q < 4'(WIN_SCORE)) score_l_d = score_l_q + 4'd1;
            state_d = (score_l_d == 4'(WIN_SCORE)) ? OVER : SERVE;
          end else begin
            if (l_hit || r_hit) begin
              paddle_d = 1'b1;
              phold_d  = HW'(HOLDOFF);
            end
            if (w_hit) begin
              wall_d  = 1'b1;
              whold_d = HW'(HOLDOFF);
            end
          end
        end
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phold_q   <= '0;
      whold_q   <= '0;
      paddle_q  <= 1'b0;
      wall_q    <= 1'b0;
      gl_q      <= 1'b0;
      gr_q      <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
    end else begin
      state_q   <= state_d;
      phold_q   <= phold_d;
      whold_q   <= whold_d;
      paddle_q  <= paddle_d;
      wall_q    <= wall_d;
      gl_q      <= gl_d;
      gr_q      <= gr_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  assign paddle_collision = paddle_q;
  assign wall_collision   = wall_q;
  assign goal_left        = gl_q;
  assign goal_right       = gr_q;
  assign score_l          = score_l_q;
  assign score_r          = score_r_q;
  assign serve_req        = (state_q == SERVE);
  assign game_over        = (state_q == OVER);

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: directed vector table, hand-written game sequences
// and random play compared against a behavioural game model.
module tb_collision_detector;

  localparam int PADDLE_H = 8;
  localparam int HOLDOFF  = 3;
  localparam int WIN      = 7;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_OVER = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pos_valid = 1'b0;
  logic [5:0] bx = '0, by = '0, lpad_y = '0, rpad_y = '0;
  logic       serve_ack = 1'b0;
  logic       paddle_collision, wall_collision, goal_left, goal_right;
  logic [3:0] score_l, score_r;
  logic       serve_req, game_over;

  collision_detector #(
    .FIELD_H(64), .COORD_W(6), .PADDLE_H(PADDLE_H), .LPAD_X(2), .RPAD_X(61),
    .WIN_SCORE(WIN), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .reset(reset), .pos_valid(pos_valid), .bx(bx), .by(by),
    .lpad_y(lpad_y), .rpad_y(rpad_y), .serve_ack(serve_ack),
    .paddle_collision(paddle_collision), .wall_collision(wall_collision),
    .goal_left(goal_left), .goal_right(goal_right),
    .score_l(score_l), .score_r(score_r),
    .serve_req(serve_req), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Game model state
  int m_phase, m_sl, m_sr, m_ph, m_wh;
  int e_pc, e_wc, e_gl, e_gr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_sl = 0; m_sr = 0; m_ph = 0; m_wh = 0;
    e_pc = 0; e_wc = 0; e_gl = 0; e_gr = 0;
  endtask

  function automatic int in_paddle(input int y, input int top);
    return (y >= top && y <= top + PADDLE_H - 1) ? 1 : 0;
  endfunction

  // One ball-move decision from the game rules, using the inputs present before the edge.
  task automatic model_step();
    int x, y, lo, ro, phit, whit;
    e_pc = 0; e_wc = 0; e_gl = 0; e_gr = 0;
    x = int'(bx); y = int'(by);
    case (m_phase)
      M_IDLE:  m_phase = M_SERVE;
      M_SERVE: if (serve_ack) begin m_phase = M_PLAY; m_ph = 0; m_wh = 0; end
      M_PLAY: if (pos_valid) begin
        lo = in_paddle(y, int'(lpad_y));
        ro = in_paddle(y, int'(rpad_y));
        phit = ((x <= 2 && lo == 1) || (x >= 61 && ro == 1)) && m_ph == 0;
        whit = (y == 0 || y == 63) && m_wh == 0;
        m_ph = (m_ph > 0) ? m_ph - 1 : 0;
        m_wh = (m_wh > 0) ? m_wh - 1 : 0;
        if (x == 0 && lo == 0) begin
          e_gl = 1; m_sr++;
          m_phase = (m_sr == WIN) ? M_OVER : M_SERVE;
        end else if (x == 63 && ro == 0) begin
          e_gr = 1; m_sl++;
          m_phase = (m_sl == WIN) ? M_OVER : M_SERVE;
        end else begin
          if (phit) begin e_pc = 1; m_ph = HOLDOFF; end
          if (whit) begin e_wc = 1; m_wh = HOLDOFF; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".paddle"}, int'(paddle_collision), e_pc);
    chk({tag, ".wall"}, int'(wall_collision), e_wc);
    chk({tag, ".goal_l"}, int'(goal_left), e_gl);
    chk({tag, ".goal_r"}, int'(goal_right), e_gr);
    chk({tag, ".score_l"}, int'(score_l), m_sl);
    chk({tag, ".score_r"}, int'(score_r), m_sr);
    chk({tag, ".serve_req"}, int'(serve_req), int'(m_phase == M_SERVE));
    chk({tag, ".game_over"}, int'(game_over), int'(m_phase == M_OVER));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_model("async_reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [5:0] pick_x();
    case ($urandom_range(0, 7))
      0: return 6'd0;
      1: return 6'd63;
      2: return 6'd2;
      3: return 6'd61;
      4: return 6'd1;
      5: return 6'd62;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic logic [5:0] pick_y(input logic [5:0] lp, input logic [5:0] rp);
    case ($urandom_range(0, 5))
      0: return 6'd0;
      1: return 6'd63;
      2: return 6'((int'(lp) + int'($urandom_range(0, 9)) + 63) % 64);
      3: return 6'((int'(rp) + int'($urandom_range(0, 9)) + 63) % 64);
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  typedef struct {
    bit pv; int x; int y; int lp; int rp;
    bit pc; bit wc; bit gl; bit gr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int over_cnt;
    vecs[0]  = '{1, 2, 24, 20, 50, 1, 0, 0, 0};  // left paddle hit
    vecs[1]  = '{0, 2, 24, 20, 50, 0, 0, 0, 0};  // idle cycle, pulse gone
    vecs[2]  = '{1, 2, 25, 20, 50, 0, 0, 0, 0};  // holdoff 3
    vecs[3]  = '{1, 2, 25, 20, 50, 0, 0, 0, 0};  // holdoff 2
    vecs[4]  = '{1, 2, 25, 20, 50, 0, 0, 0, 0};  // holdoff 1
    vecs[5]  = '{1, 2, 25, 20, 50, 1, 0, 0, 0};  // holdoff expired
    vecs[6]  = '{1, 30, 0, 20, 50, 0, 1, 0, 0};  // top wall
    vecs[7]  = '{1, 30, 63, 20, 50, 0, 0, 0, 0}; // bottom wall masked
    vecs[8]  = '{1, 30, 30, 20, 50, 0, 0, 0, 0};
    vecs[9]  = '{1, 30, 30, 20, 50, 0, 0, 0, 0};
    vecs[10] = '{1, 61, 0, 20, 0, 1, 1, 0, 0};   // corner: paddle + wall
    vecs[11] = '{1, 0, 10, 40, 0, 0, 0, 1, 0};   // left goal, paddle elsewhere

    model_reset();
    #12;
    check_model("reset_held");
    reset = 1'b0;
    #1;
    check_model("reset_release");
    tick("to_serve");
    chk("serve_req_on", int'(serve_req), 1);
    serve_ack = 1'b1;
    tick("serve_ack");
    serve_ack = 1'b0;
    chk("serve_req_off", int'(serve_req), 0);

    for (int i = 0; i < 12; i++) begin
      pos_valid = vecs[i].pv;
      bx = 6'(vecs[i].x); by = 6'(vecs[i].y);
      lpad_y = 6'(vecs[i].lp); rpad_y = 6'(vecs[i].rp);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.pc", i), int'(paddle_collision), int'(vecs[i].pc));
      chk($sformatf("vec%0d.wc", i), int'(wall_collision), int'(vecs[i].wc));
      chk($sformatf("vec%0d.gl", i), int'(goal_left), int'(vecs[i].gl));
      chk($sformatf("vec%0d.gr", i), int'(goal_right), int'(vecs[i].gr));
    end
    chk("goal.score_r", int'(score_r), 1);
    chk("goal.serve_req", int'(serve_req), 1);
    pos_valid = 1'b0;
    tick("goal_after");

    // Random play with occasional asynchronous resets
    over_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0 || over_cnt > 6) begin
        do_reset();
        over_cnt = 0;
      end
      serve_ack = ($urandom_range(0, 9) < 3);
      pos_valid = ($urandom_range(0, 9) < 7);
      lpad_y = 6'($urandom_range(0, 63));
      rpad_y = 6'($urandom_range(0, 63));
      bx = pick_x();
      by = pick_y(lpad_y, rpad_y);
      tick("rand");
      if (m_phase == M_OVER) over_cnt++;
    end

    // Left player wins with seven right-side exits
    serve_ack = 1'b0; pos_valid = 1'b0;
    do_reset();
    tick("win_idle");
    for (int g = 0; g < 7; g++) begin
      serve_ack = 1'b1;
      tick("win_serve");
      serve_ack = 1'b0;
      pos_valid = 1'b1; bx = 6'd63; by = 6'd40; rpad_y = 6'd0; lpad_y = 6'd20;
      tick("win_goal");
      chk($sformatf("win_goal%0d", g), int'(goal_right), 1);
      pos_valid = 1'b0;
    end
    chk("win.score_l", int'(score_l), 7);
    chk("win.game_over", int'(game_over), 1);
    pos_valid = 1'b1; serve_ack = 1'b1; bx = 6'd0; by = 6'd0;
    for (int k = 0; k < 5; k++) tick("over_hold");
    chk("over.score_l", int'(score_l), 7);
    chk("over.goal_l", int'(goal_left), 0);
    pos_valid = 1'b0; serve_ack = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("over_reset.score_l", int'(score_l), 0);
    chk("over_reset.game_over", int'(game_over), 0);
    model_reset();
    check_model("over_reset");
    @(negedge clk);
    reset = 1'b0;
    tick("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
